// File: rtl/linear_layer_start_fifo_srl_ctrl_pkg.sv
// Shared definitions for the SRL-style start FIFO: controller state encoding.
package linear_layer_start_fifo_srl_ctrl_pkg;

  // Occupancy class of the FIFO; drives both registered status flags.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/linear_layer_start_fifo_srl_ctrl_if.sv
// Producer/consumer handshake bundle for the SRL start FIFO.
interface linear_layer_start_fifo_srl_ctrl_if #(
  parameter int DATA_WIDTH = 1
);
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;

  // Environment side: drives requests and push data, observes status.
  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
    input  if_full_n, if_dout, if_empty_n
  );

  // FIFO side.
  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
    output if_full_n, if_dout, if_empty_n
  );
endinterface

// File: rtl/linear_layer_start_fifo_srl_store.sv
// Shift-register storage: every write shifts all entries one deeper and
// loads the new token at entry 0; reads are addressed and combinational.
module linear_layer_start_fifo_srl_store #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  shift_en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Shift chain; deliberately not reset so it maps onto SRL primitives.
  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  // The oldest token sits at the deepest occupied entry, selected by addr_i.
  assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/linear_layer_start_fifo_srl_ctrl.sv
// SRL start FIFO controller: occupancy counter, read address, three-state
// FSM and registered empty/full flags around the shift-register store.
module linear_layer_start_fifo_srl_ctrl
  import linear_layer_start_fifo_srl_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                               clk,
  input  logic                               reset_n,
  linear_layer_start_fifo_srl_ctrl_if.slave  fifo_if
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fifo_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  empty_n_q, empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  push, pop;

  // Requests only take effect when enabled and the registered flag allows it.
  assign push = fifo_if.if_write_ce & fifo_if.if_write & full_n_q;
  assign pop  = fifo_if.if_read_ce  & fifo_if.if_read  & empty_n_q;

  // Next-state logic for counter, FSM, flags and read address.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    unique case (state_q)
      ST_EMPTY: begin
        if (push) state_d = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (pop && !push && cnt_q == CNT_W'(1)) begin
          state_d = ST_EMPTY;
        end else if (push && !pop && cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (pop && !push) state_d = ST_PARTIAL;
      end
      default: state_d = ST_EMPTY;
    endcase

    empty_n_d = (state_d != ST_EMPTY);
    full_n_d  = (state_d != ST_FULL);

    // Oldest token lives at entry cnt-1; park at 0 when nothing is stored.
    if (cnt_d == '0) begin
      raddr_d = '0;
    end else begin
      raddr_d = ADDR_WIDTH'(cnt_d - CNT_W'(1));
    end
  end

  // Control registers; reset clears occupancy but leaves storage untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_EMPTY;
      cnt_q     <= '0;
      raddr_q   <= '0;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      raddr_q   <= raddr_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
    end
  end

  assign fifo_if.if_empty_n = empty_n_q;
  assign fifo_if.if_full_n  = full_n_q;

  linear_layer_start_fifo_srl_store #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_store (
    .clk        (clk),
    .shift_en_i (push),
    .din_i      (fifo_if.if_din),
    .addr_i     (raddr_q),
    .dout_o     (fifo_if.if_dout)
  );

endmodule

// File: tb/tb_linear_layer_start_fifo_srl_ctrl.sv
// Scoreboard bench for the SRL start FIFO (8-bit tokens, depth 2).
module tb_linear_layer_start_fifo_srl_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 1;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  linear_layer_start_fifo_srl_ctrl_if #(.DATA_WIDTH(DW)) fifo_if ();

  linear_layer_start_fifo_srl_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .fifo_if (fifo_if.slave)
  );

  // One clock of stimulus; expected pops are compared against the queue head
  // before the edge, accepted pushes are appended after it.
  task automatic step(input logic wce, input logic w, input logic [DW-1:0] d,
                      input logic rce, input logic r);
    bit do_push, do_pop;
    do_pop  = rce && r && (exp_q.size() > 0);
    do_push = wce && w && (exp_q.size() < DEPTH);
    if (do_pop) begin
      checks++;
      if (fifo_if.if_dout !== exp_q[0]) begin
        errors++;
        $display("FAIL pop_data: got %02h expected %02h", fifo_if.if_dout, exp_q[0]);
      end else begin
        $display("pop  %02h ok", fifo_if.if_dout);
      end
    end
    fifo_if.if_write_ce = wce;
    fifo_if.if_write    = w;
    fifo_if.if_din      = d;
    fifo_if.if_read_ce  = rce;
    fifo_if.if_read     = r;
    @(posedge clk);
    #1;
    fifo_if.if_write_ce = 1'b0;
    fifo_if.if_write    = 1'b0;
    fifo_if.if_read_ce  = 1'b0;
    fifo_if.if_read     = 1'b0;
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      exp_q.push_back(d);
      $display("push %02h accepted", d);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    fifo_if.if_write_ce = 1'b0;
    fifo_if.if_write    = 1'b0;
    fifo_if.if_din      = '0;
    fifo_if.if_read_ce  = 1'b0;
    fifo_if.if_read     = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (fifo_if.if_empty_n !== 1'b0 || fifo_if.if_full_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: got empty_n=%b full_n=%b expected 0 1",
               fifo_if.if_empty_n, fifo_if.if_full_n);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_push();
    step(1, 1, 8'hA5, 0, 0);
    checks++;
    if (fifo_if.if_empty_n !== 1'b1 || fifo_if.if_full_n !== 1'b1 || fifo_if.if_dout !== 8'hA5) begin
      errors++;
      $display("FAIL single_push: got empty_n=%b full_n=%b dout=%02h expected 1 1 a5",
               fifo_if.if_empty_n, fifo_if.if_full_n, fifo_if.if_dout);
    end
    step(0, 0, 0, 1, 1);
    checks++;
    if (fifo_if.if_empty_n !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got empty_n=%b expected 0", fifo_if.if_empty_n);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 8'h11, 0, 0);
    step(1, 1, 8'h22, 0, 0);
    checks++;
    if (fifo_if.if_full_n !== 1'b0 || fifo_if.if_empty_n !== 1'b1) begin
      errors++;
      $display("FAIL fill_flags: got full_n=%b empty_n=%b expected 0 1",
               fifo_if.if_full_n, fifo_if.if_empty_n);
    end
    step(1, 1, 8'h33, 0, 0);   // rejected: FIFO full
    checks++;
    if (fifo_if.if_full_n !== 1'b0 || fifo_if.if_dout !== 8'h11) begin
      errors++;
      $display("FAIL push_while_full: got full_n=%b dout=%02h expected 0 11",
               fifo_if.if_full_n, fifo_if.if_dout);
    end
    step(0, 0, 0, 1, 1);
    checks++;
    if (fifo_if.if_full_n !== 1'b1 || fifo_if.if_empty_n !== 1'b1) begin
      errors++;
      $display("FAIL pop_from_full: got full_n=%b empty_n=%b expected 1 1",
               fifo_if.if_full_n, fifo_if.if_empty_n);
    end
    step(0, 0, 0, 1, 1);
    checks++;
    if (fifo_if.if_empty_n !== 1'b0 || fifo_if.if_full_n !== 1'b1) begin
      errors++;
      $display("FAIL drain_flags: got empty_n=%b full_n=%b expected 0 1",
               fifo_if.if_empty_n, fifo_if.if_full_n);
    end
  endtask

  task automatic test_push_pop();
    step(1, 1, 8'h11, 0, 0);
    step(1, 1, 8'h22, 1, 1);   // pops 0x11, appends 0x22
    checks++;
    if (fifo_if.if_dout !== 8'h22 || fifo_if.if_empty_n !== 1'b1 || fifo_if.if_full_n !== 1'b1) begin
      errors++;
      $display("FAIL push_pop: got dout=%02h empty_n=%b full_n=%b expected 22 1 1",
               fifo_if.if_dout, fifo_if.if_empty_n, fifo_if.if_full_n);
    end
    step(0, 0, 0, 1, 1);
    checks++;
    if (fifo_if.if_empty_n !== 1'b0) begin
      errors++;
      $display("FAIL push_pop_drain: got empty_n=%b expected 0 (count should have been 1)",
               fifo_if.if_empty_n);
    end
  endtask

  task automatic test_pop_empty();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 1);
      checks++;
      if (fifo_if.if_empty_n !== 1'b0 || fifo_if.if_full_n !== 1'b1) begin
        errors++;
        $display("FAIL pop_empty[%0d]: got empty_n=%b full_n=%b expected 0 1",
                 i, fifo_if.if_empty_n, fifo_if.if_full_n);
      end
    end
    step(1, 1, 8'h5C, 0, 0);   // a phantom pop would have corrupted the count
    step(0, 0, 0, 1, 1);
    checks++;
    if (fifo_if.if_empty_n !== 1'b0) begin
      errors++;
      $display("FAIL pop_empty_recover: got empty_n=%b expected 0", fifo_if.if_empty_n);
    end
  endtask

  task automatic test_ce_gating();
    step(0, 1, 8'h77, 0, 0);
    checks++;
    if (fifo_if.if_empty_n !== 1'b0) begin
      errors++;
      $display("FAIL write_ce_gate: got empty_n=%b expected 0", fifo_if.if_empty_n);
    end
    step(1, 1, 8'h12, 0, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if (fifo_if.if_empty_n !== 1'b1 || fifo_if.if_dout !== 8'h12) begin
      errors++;
      $display("FAIL read_ce_gate: got empty_n=%b dout=%02h expected 1 12",
               fifo_if.if_empty_n, fifo_if.if_dout);
    end
    step(0, 0, 0, 1, 1);
  endtask

  task automatic test_reset_mid();
    step(1, 1, 8'h55, 0, 0);
    step(1, 1, 8'h66, 0, 0);
    checks++;
    if (fifo_if.if_full_n !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_full: got full_n=%b expected 0", fifo_if.if_full_n);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (fifo_if.if_empty_n !== 1'b0 || fifo_if.if_full_n !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got empty_n=%b full_n=%b expected 0 1",
               fifo_if.if_empty_n, fifo_if.if_full_n);
    end
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 1, 8'h44, 0, 0);
    checks++;
    if (fifo_if.if_empty_n !== 1'b1 || fifo_if.if_dout !== 8'h44) begin
      errors++;
      $display("FAIL post_reset_push: got empty_n=%b dout=%02h expected 1 44",
               fifo_if.if_empty_n, fifo_if.if_dout);
    end
    step(0, 0, 0, 1, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      checks++;
      if (fifo_if.if_empty_n !== (exp_q.size() != 0) || fifo_if.if_full_n !== (exp_q.size() != DEPTH)) begin
        errors++;
        $display("FAIL random_flags[%0d]: got empty_n=%b full_n=%b expected occupancy %0d",
                 i, fifo_if.if_empty_n, fifo_if.if_full_n, exp_q.size());
      end
    end
    while (exp_q.size() > 0) step(0, 0, 0, 1, 1);
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_back_to_back();
    test_push_pop();
    test_pop_empty();
    test_ce_gating();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
